store_monitor: RTL

Passive observer on the processor's data-memory write port. Every cycle it samples `MemWrite`/`DataAdr`/`WriteData` from `top` and classifies each store against pass, checkpoint and fail rules. It records the verdict in sticky status registers and queues each captured store in a small FIFO drained over a valid/ready port to a host or trace sink. It replaces ad-hoc negedge checking with a synthesizable, cycle-exact monitor usable in simulation and on FPGA.

---
 rtl/store_monitor.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/store_monitor.sv
// -----------------------------------------------------------------------------
// store_monitor
//
// Passive observer on the processor data-memory write port. Each store seen
// while the run is still in progress is classified (pass / checkpoint / fail),
// recorded in sticky status registers and queued in a small FIFO that a host or
// trace sink drains over a valid/ready port.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high
//   MemWrite    in   store strobe from the processor
//   DataAdr     in   store address [31:0]
//   WriteData   in   store data [31:0]
//   out_valid   out  FIFO head is valid
//   out_ready   in   sink accepts the head
//   out_addr    out  head address [31:0] (0 when empty)
//   out_data    out  head data [31:0] (0 when empty)
//   status      out  00 RUN, 01 PASS, 10 FAIL
//   chk_hit     out  sticky: checkpoint store with correct data seen
//   chk_bad     out  sticky: checkpoint store with wrong data seen
//   overflow    out  sticky: at least one store dropped on a full FIFO
//   drop_count  out  dropped stores, saturating at 255
// -----------------------------------------------------------------------------
module store_monitor #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] PASS_ADDR = 32'd32,
  parameter logic [31:0] PASS_DATA = 32'd25,
  parameter logic [31:0] CHK_ADDR  = 32'd96,
  parameter logic [31:0] CHK_DATA  = 32'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [1:0]  status,
  output logic        chk_hit,
  output logic        chk_bad,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10
  } state_t;

  state_t state_reg, state_next;

  logic          chk_hit_reg, chk_bad_reg, overflow_reg;
  logic [7:0]    drop_count_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic [31:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  // Per-cycle decode of the store on the port.
  logic sample, is_pass, is_chk, chk_good;
  logic push, pop, drop;

  assign sample   = MemWrite && (state_reg == ST_RUN);
  assign is_pass  = (DataAdr == PASS_ADDR) && (WriteData == PASS_DATA);
  assign is_chk   = (DataAdr == CHK_ADDR);
  assign chk_good = (WriteData == CHK_DATA);

  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign push      = sample && ((count_reg < DEPTH_C) || pop);
  assign drop      = sample && !push;

  // Status FSM: RUN is the only non-terminal state.
  always_comb begin
    state_next = state_reg;
    if (sample) begin
      if (is_pass)
        state_next = ST_PASS;
      else if (!is_chk)
        state_next = ST_FAIL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_RUN;
      chk_hit_reg    <= 1'b0;
      chk_bad_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      // The pass rule takes precedence, so a checkpoint flag only moves when
      // the store was not already classified as a pass.
      if (sample && !is_pass && is_chk) begin
        if (chk_good)
          chk_hit_reg <= 1'b1;
        else
          chk_bad_reg <= 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 8'hFF)
          drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  // FIFO bookkeeping. Pointers are AW bits and wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage array; contents need no reset because the head is masked when
  // the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= DataAdr;
      data_mem[wr_ptr_reg] <= WriteData;
    end
  end

  // The head must be visible in the cycle right after the push, so it is read
  // combinationally from the array; it only changes on a pop, which keeps it
  // stable while the sink stalls.
  assign out_addr = out_valid ? addr_mem[rd_ptr_reg] : 32'd0;
  assign out_data = out_valid ? data_mem[rd_ptr_reg] : 32'd0;

  assign status     = state_reg;
  assign chk_hit    = chk_hit_reg;
  assign chk_bad    = chk_bad_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule
